// File: rtl/debug_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_halt_ctrl
// Description : Debug halt controller. Sequences the core through drain,
//               flush, halted and resume on external debug-module requests.
//               Optional single-step support under DEBUG_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_halt_ctrl #(
    parameter int DRAIN_TIMEOUT = 16,
    parameter int RESET_CYCLES  = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dm_haltreq_i,
    input  logic        dm_resumereq_i,
`ifdef DEBUG_SINGLE_STEP_EN
    input  logic        dm_step_i,
`endif
    output logic        dm_halted_o,
    output logic        dm_running_o,
    output logic        dm_resumeack_o,
    output logic        dm_timeout_o,
    input  logic [31:0] pc_i,
    output logic [31:0] dpc_o,
    output logic        DSP_halt_active_o,
    output logic        DSP_reset_stages_o,
    input  logic        DSP_inst_comp_i
);

    localparam int DW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int RW = $clog2(RESET_CYCLES) + 1;

    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [RW-1:0] FLUSH_LAST = RW'(RESET_CYCLES - 1);

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_FLUSH  = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;
    localparam logic [2:0] S_RESUME = 3'd4;

    logic [2:0]    state_q,     state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [RW-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]   dpc_q,       dpc_d;
    logic          timeout_q,   timeout_d;
    logic          halted_q,    halted_d;
    logic          running_q,   running_d;
    logic          ack_q,       ack_d;
    logic          halt_act_q,  halt_act_d;
    logic          rst_stg_q,   rst_stg_d;
    logic          w_enter_drain;

`ifdef DEBUG_SINGLE_STEP_EN
    logic          step_q,      step_d;

    // A pending step re-halts after the single RUN cycle following RESUME.
    assign w_enter_drain = dm_haltreq_i | step_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`else
    assign w_enter_drain = dm_haltreq_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
            flush_cnt_q <= '0;
            dpc_q       <= '0;
            timeout_q   <= 1'b0;
            halted_q    <= 1'b0;
            running_q   <= 1'b1;
            ack_q       <= 1'b0;
            halt_act_q  <= 1'b0;
            rst_stg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            dpc_q       <= dpc_d;
            timeout_q   <= timeout_d;
            halted_q    <= halted_d;
            running_q   <= running_d;
            ack_q       <= ack_d;
            halt_act_q  <= halt_act_d;
            rst_stg_q   <= rst_stg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = '0;
        flush_cnt_d = '0;
        dpc_d       = dpc_q;
        timeout_d   = timeout_q;
`ifdef DEBUG_SINGLE_STEP_EN
        step_d      = step_q;
`endif
        case (state_q)
            S_RUN: begin
                if (w_enter_drain) begin
                    state_d   = S_DRAIN;
                    dpc_d     = pc_i;
                    timeout_d = 1'b0;
`ifdef DEBUG_SINGLE_STEP_EN
                    step_d    = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DW'(1);
                // Completion takes priority over a timeout in the same cycle.
                if (DSP_inst_comp_i) begin
                    state_d = S_FLUSH;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = S_FLUSH;
                    timeout_d = 1'b1;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q + RW'(1);
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (dm_resumereq_i && !dm_haltreq_i) begin
                    state_d = S_RESUME;
`ifdef DEBUG_SINGLE_STEP_EN
                    step_d  = dm_step_i;
`endif
                end
            end
            S_RESUME: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
        if (state_d != state_q) begin
            drain_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_comb begin
        halt_act_d = (state_d == S_DRAIN) || (state_d == S_FLUSH) || (state_d == S_HALTED);
        rst_stg_d  = (state_d == S_FLUSH);
        halted_d   = (state_d == S_HALTED);
        running_d  = (state_d == S_RUN);
        ack_d      = (state_d == S_RESUME);
    end

    assign dm_halted_o        = halted_q;
    assign dm_running_o       = running_q;
    assign dm_resumeack_o     = ack_q;
    assign dm_timeout_o       = timeout_q;
    assign dpc_o              = dpc_q;
    assign DSP_halt_active_o  = halt_act_q;
    assign DSP_reset_stages_o = rst_stg_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_halt_ctrl
// Description : Randomized scoreboard bench for debug_halt_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debug_halt_ctrl;

    localparam int DT  = 16;
    localparam int RC  = 1;
    localparam int RC2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, haltreq, resumereq, inst_comp;
    logic [31:0] pc;
    logic        halted, running, ack, tmo, ha, rs;
    logic [31:0] dpc;

    logic        rst2, haltreq2, inst_comp2;
    logic [31:0] pc2;
    logic        halted2, running2, ack2, tmo2, ha2, rs2;
    logic [31:0] dpc2;
`ifdef DEBUG_SINGLE_STEP_EN
    logic        step;
    logic        step2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    debug_halt_ctrl #(.DRAIN_TIMEOUT(DT), .RESET_CYCLES(RC)) u_dut (
        .clk_i(clk), .reset_i(rst),
        .dm_haltreq_i(haltreq), .dm_resumereq_i(resumereq),
`ifdef DEBUG_SINGLE_STEP_EN
        .dm_step_i(step),
`endif
        .dm_halted_o(halted), .dm_running_o(running), .dm_resumeack_o(ack),
        .dm_timeout_o(tmo), .pc_i(pc), .dpc_o(dpc),
        .DSP_halt_active_o(ha), .DSP_reset_stages_o(rs), .DSP_inst_comp_i(inst_comp)
    );

    debug_halt_ctrl #(.DRAIN_TIMEOUT(DT), .RESET_CYCLES(RC2)) u_dut4 (
        .clk_i(clk), .reset_i(rst2),
        .dm_haltreq_i(haltreq2), .dm_resumereq_i(1'b0),
`ifdef DEBUG_SINGLE_STEP_EN
        .dm_step_i(step2),
`endif
        .dm_halted_o(halted2), .dm_running_o(running2), .dm_resumeack_o(ack2),
        .dm_timeout_o(tmo2), .pc_i(pc2), .dpc_o(dpc2),
        .DSP_halt_active_o(ha2), .DSP_reset_stages_o(rs2), .DSP_inst_comp_i(inst_comp2)
    );

    typedef struct {
        logic [31:0] dpc;
        logic        tmo;
        int          at;
    } halt_exp_t;

    halt_exp_t hq[$];
    int        aq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: halted rising edge, resume ack and reset_stages pulse width.
    logic halted_prev = 1'b0;
    int   rs_cnt      = 0;
    always @(negedge clk) begin
        halt_exp_t e;
        if (!rst) begin
            if (halted && !halted_prev) begin
                if (hq.size() == 0) begin
                    chk("unexpected_halt", 32'(halted), 32'd0);
                end else begin
                    e = hq.pop_front();
                    chk("halt_cycle", 32'(cyc), 32'(e.at));
                    chk("halt_dpc", dpc, e.dpc);
                    chk("halt_timeout", 32'(tmo), 32'(e.tmo));
                    chk("halt_active_in_halted", 32'(ha), 32'd1);
                    chk("running_in_halted", 32'(running), 32'd0);
                end
            end
            if (ack) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    chk("ack_cycle", 32'(cyc), 32'(aq.pop_front()));
                    chk("ack_halt_active", 32'(ha), 32'd0);
                    chk("ack_status", {30'd0, halted, running}, 32'd0);
                end
            end
            if (rs) begin
                rs_cnt++;
            end else if (rs_cnt != 0) begin
                chk("reset_stages_width", 32'(rs_cnt), 32'(RC));
                rs_cnt = 0;
            end
        end
        halted_prev = rst ? 1'b0 : halted;
    end

    // Reference rule: DRAIN lasts k cycles if inst_comp arrives in DRAIN cycle
    // k <= DT, else DT cycles with timeout; halted shows len+RC edges after E0.
    task automatic do_halt(input int k, input logic [31:0] p);
        halt_exp_t ex;
        int        e0;
        haltreq = 1'b1;
        pc      = p;
        e0      = cyc + 1;
        ex.dpc  = p;
        ex.tmo  = (k > DT);
        ex.at   = e0 + ((k <= DT) ? k : DT) + RC;
        hq.push_back(ex);
        tick(1);
        chk("drain_dpc_capture", dpc, p);
        chk("drain_halt_active", 32'(ha), 32'd1);
        chk("drain_timeout_clear", 32'(tmo), 32'd0);
        pc      = $urandom;
        haltreq = 1'($urandom_range(0, 1));
        if (k <= DT) begin
            tick(k - 1);
            inst_comp = 1'b1;
        end
        for (int i = 0; i < DT + RC + 10 && !halted; i++) tick(1);
        if (!halted) chk("halt_wait_bound", 32'(halted), 32'd1);
        inst_comp = 1'b0;
        haltreq   = 1'b0;
    endtask

    task automatic do_resume(input int both_cycles);
        haltreq   = 1'b1;
        resumereq = 1'b1;
        tick(both_cycles);
        chk("halt_priority", 32'(halted), 32'd1);
        haltreq = 1'b0;
        aq.push_back(cyc + 1);
        tick(4);
        resumereq = 1'b0;
        chk("running_after_resume", 32'(running), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        rst = 1'b1; rst2 = 1'b1;
        haltreq = 1'b1; resumereq = 1'b0; inst_comp = 1'b0; pc = 32'h0000_1000;
        haltreq2 = 1'b0; inst_comp2 = 1'b0; pc2 = 32'h0;
`ifdef DEBUG_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(3);
        chk("reset_status", {30'd0, halted, running}, 32'd1);
        chk("reset_dsp", {30'd0, ha, rs}, 32'd0);
        chk("reset_ack_tmo", {30'd0, ack, tmo}, 32'd0);
        chk("reset_dpc", dpc, 32'd0);
        rst = 1'b0; rst2 = 1'b0;
        #2;
        chk("post_reset_running", 32'(running), 32'd1);
        chk("post_reset_halt_active", 32'(ha), 32'd0);
        do_halt(3, 32'h0000_1000);
        do_resume(1);

        do_halt(2, 32'h0000_0040);
        do_resume(2);
        do_halt(99, 32'hDEAD_BEE0);
        do_resume(3);
        do_halt(DT, 32'h1234_5678);
        do_resume(1);
        for (int n = 0; n < 12; n++) begin
            pc = $urandom;
            tick($urandom_range(0, 3));
            p = $urandom;
            do_halt(($urandom_range(0, 3) == 0) ? DT + 1 : $urandom_range(1, DT + 2), p);
            do_resume($urandom_range(1, 3));
        end

`ifdef DEBUG_SINGLE_STEP_EN
        begin
            halt_exp_t ex;
            int        c;
            do_halt(1, 32'h0000_0040);
            pc = 32'h0000_0040; step = 1'b1; resumereq = 1'b1; haltreq = 1'b0;
            c = cyc;
            aq.push_back(c + 1);
            ex.dpc = 32'h0000_0044; ex.tmo = 1'b0; ex.at = c + 3 + 1 + RC;
            hq.push_back(ex);
            tick(1);
            pc = 32'h0000_0044; step = 1'b0; resumereq = 1'b0; inst_comp = 1'b1;
            for (int i = 0; i < DT + RC + 10 && !halted; i++) tick(1);
            if (!halted) chk("step_wait_bound", 32'(halted), 32'd1);
            inst_comp = 1'b0;
            tick(2);
            do_resume(1);
        end
`endif

        // Asynchronous reset in the second FLUSH cycle of the RESET_CYCLES=4 copy.
        pc2 = 32'hCAFE_0010; haltreq2 = 1'b1; inst_comp2 = 1'b1;
        tick(1);
        haltreq2 = 1'b0;
        tick(2);
        chk("flush2_reset_stages", 32'(rs2), 32'd1);
        chk("flush2_dpc", dpc2, 32'hCAFE_0010);
        #2 rst2 = 1'b1;
        #1;
        chk("async_rst_dsp", {30'd0, ha2, rs2}, 32'd0);
        chk("async_rst_running", 32'(running2), 32'd1);
        chk("async_rst_dpc", dpc2, 32'd0);
        tick(1);
        rst2 = 1'b0; inst_comp2 = 1'b0;
        tick(2);

        chk("halt_queue_empty", 32'(hq.size()), 32'd0);
        chk("ack_queue_empty", 32'(aq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
